conv_tap_pos_sequencer: RTL

- Upstream driver for surface_pos_logic_to_phy.
- Walks every output position of a convolution over the extended (padded) feature map and every kernel tap at that position.
- Issues one logical (x,y) per tap to the converter through its blk handshake.
- Forwards each converted physical position, plus its valid/padding flag, as a valid/ready stream to the downstream feature-fetch stage.

---
 rtl/conv_tap_pos_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_tap_pos_sequencer.sv
// Walks every output position and kernel tap of a convolution over the padded map, issues each
// logical (x,y) to the position converter and streams the converted positions downstream.
module conv_tap_pos_sequencer #(
  parameter int SIM_DELAY = 1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        aclken,
  input  logic [15:0] ofmap_w_m1,
  input  logic [15:0] ofmap_h_m1,
  input  logic [2:0]  kernel_w_m1,
  input  logic [2:0]  kernel_h_m1,
  input  logic [2:0]  stride_x_m1,
  input  logic [2:0]  stride_y_m1,
  input  logic        blk_start,
  output logic        blk_idle,
  output logic        blk_done,
  output logic        cvt_start,
  input  logic        cvt_idle,
  output logic [15:0] cvt_logic_x,
  output logic [15:0] cvt_logic_y,
  output logic        cvt_en_x_cvt,
  output logic        cvt_en_y_cvt,
  input  logic        cvt_done,
  input  logic [15:0] cvt_phy_x,
  input  logic [15:0] cvt_phy_y,
  input  logic        cvt_is_vld,
  output logic        m_pos_valid,
  input  logic        m_pos_ready,
  output logic [15:0] m_pos_x,
  output logic [15:0] m_pos_y,
  output logic        m_pos_is_vld,
  output logic        m_pos_last_tap,
  output logic        m_pos_last
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StOut, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] ow_q, ow_d, oh_q, oh_d;
  logic [2:0]  kw_q, kw_d, kh_q, kh_d, sx_q, sx_d, sy_q, sy_d;
  logic [2:0]  kx_q, kx_d, ky_q, ky_d;
  logic [15:0] ox_q, ox_d, oy_q, oy_d;
  logic [15:0] base_x_q, base_x_d, base_y_q, base_y_d;
  logic        start_q, start_d;
  logic        valid_q, valid_d;
  logic [15:0] px_q, px_d, py_q, py_d;
  logic        vld_q, vld_d, last_tap_q, last_tap_d, last_q, last_d;
  logic        tap_is_last;

  assign tap_is_last = (kx_q == kw_q) && (ky_q == kh_q);

  always_comb begin
    state_d    = state_q;
    ow_d       = ow_q;
    oh_d       = oh_q;
    kw_d       = kw_q;
    kh_d       = kh_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    base_x_d   = base_x_q;
    base_y_d   = base_y_q;
    start_d    = start_q;
    valid_d    = valid_q;
    px_d       = px_q;
    py_d       = py_q;
    vld_d      = vld_q;
    last_tap_d = last_tap_q;
    last_d     = last_q;
    // With aclken low every register keeps its value, outputs included.
    if (aclken) begin
      start_d = 1'b0;
      case (state_q)
        StIdle: begin
          if (blk_start) begin
            ow_d     = ofmap_w_m1;
            oh_d     = ofmap_h_m1;
            kw_d     = kernel_w_m1;
            kh_d     = kernel_h_m1;
            sx_d     = stride_x_m1;
            sy_d     = stride_y_m1;
            kx_d     = 3'd0;
            ky_d     = 3'd0;
            ox_d     = 16'd0;
            oy_d     = 16'd0;
            base_x_d = 16'd0;
            base_y_d = 16'd0;
            state_d  = StIssue;
          end
        end
        StIssue: begin
          if (cvt_idle) begin
            start_d = 1'b1;
            state_d = StWait;
          end
        end
        StWait: begin
          if (cvt_done) begin
            px_d       = cvt_phy_x;
            py_d       = cvt_phy_y;
            vld_d      = cvt_is_vld;
            last_tap_d = tap_is_last;
            last_d     = tap_is_last && (ox_q == ow_q) && (oy_q == oh_q);
            valid_d    = 1'b1;
            state_d    = StOut;
          end
        end
        StOut: begin
          if (m_pos_ready) begin
            valid_d = 1'b0;
            if (last_q) begin
              state_d = StDone;
            end else begin
              state_d = StIssue;
              if (kx_q != kw_q) begin
                kx_d = kx_q + 3'd1;
              end else begin
                kx_d = 3'd0;
                if (ky_q != kh_q) begin
                  ky_d = ky_q + 3'd1;
                end else begin
                  ky_d = 3'd0;
                  if (ox_q != ow_q) begin
                    ox_d     = ox_q + 16'd1;
                    base_x_d = base_x_q + {13'd0, sx_q} + 16'd1;
                  end else begin
                    ox_d     = 16'd0;
                    base_x_d = 16'd0;
                    oy_d     = oy_q + 16'd1;
                    base_y_d = base_y_q + {13'd0, sy_q} + 16'd1;
                  end
                end
              end
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= StIdle;
      ow_q       <= 16'd0;
      oh_q       <= 16'd0;
      kw_q       <= 3'd0;
      kh_q       <= 3'd0;
      sx_q       <= 3'd0;
      sy_q       <= 3'd0;
      kx_q       <= 3'd0;
      ky_q       <= 3'd0;
      ox_q       <= 16'd0;
      oy_q       <= 16'd0;
      base_x_q   <= 16'd0;
      base_y_q   <= 16'd0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      px_q       <= 16'd0;
      py_q       <= 16'd0;
      vld_q      <= 1'b0;
      last_tap_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ow_q       <= ow_d;
      oh_q       <= oh_d;
      kw_q       <= kw_d;
      kh_q       <= kh_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      base_x_q   <= base_x_d;
      base_y_q   <= base_y_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      px_q       <= px_d;
      py_q       <= py_d;
      vld_q      <= vld_d;
      last_tap_q <= last_tap_d;
      last_q     <= last_d;
    end
  end

  // cvt_start is registered, so the logical position it carries is already stable in WAIT.
  assign cvt_start      = start_q;
  assign cvt_logic_x    = base_x_q + {13'd0, kx_q};
  assign cvt_logic_y    = base_y_q + {13'd0, ky_q};
  assign cvt_en_x_cvt   = 1'b1;
  assign cvt_en_y_cvt   = 1'b1;
  assign blk_idle       = (state_q == StIdle);
  assign blk_done       = (state_q == StDone);
  assign m_pos_valid    = valid_q;
  assign m_pos_x        = px_q;
  assign m_pos_y        = py_q;
  assign m_pos_is_vld   = vld_q;
  assign m_pos_last_tap = last_tap_q;
  assign m_pos_last     = last_q;

endmodule
